// File: rtl/imem_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl_pkg
// Description : Shared types for the UART boot loader and its consumers
//               (state encoding, header size, memory write bundle).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_load_ctrl_pkg;

  // Loader state encoding, explicit 3-bit width.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_HDR0 = 3'd2,
    ST_HDR1 = 3'd3,
    ST_DATA = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } type_ldr_state_e;

  // The stream starts with a little-endian 16-bit word count.
  localparam int LDR_HDR_BYTES = 2;

  // One write bundle so imem and fetch consume a single signal.
  typedef struct packed {
    logic        we;
    logic [15:0] waddr;
    logic [31:0] wdata;
  } type_ldr2imem_s;

  // A load is in flight while the header or payload is being received.
  function automatic logic ldr_is_busy(input type_ldr_state_e s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl_if
// Description : Bundle of loader control, UART byte stream and
//               instruction-memory write signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_load_ctrl_if #(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR      = 10
);
  logic                 load_req;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 imem_we;
  logic [ADDR-3:0]      imem_waddr;
  logic [BUS_WIDTH-1:0] imem_wdata;
  logic                 core_rst;
  logic                 load_busy;
  logic                 load_err;
  logic [15:0]          words_loaded;

  // Side that issues load requests and supplies UART bytes.
  modport master (
    output load_req, rx_valid, rx_data,
    input  imem_we, imem_waddr, imem_wdata, core_rst, load_busy, load_err, words_loaded
  );

  // Loader controller side.
  modport slave (
    input  load_req, rx_valid, rx_data,
    output imem_we, imem_waddr, imem_wdata, core_rst, load_busy, load_err, words_loaded
  );
endinterface
`default_nettype wire

// File: rtl/imem_load_ctrl_uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_packer
// Description : Packs UART bytes, least-significant first, into 32-bit words.
//               The word strobe is combinational on the fourth byte; the
//               caller registers it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_packer (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        clr,
  input  wire logic        byte_valid,
  input  wire logic [7:0]  byte_data,
  output logic             word_valid,
  output logic [31:0]      word_data
);

  logic [1:0]  r_idx;
  logic [23:0] r_buf;

  // Byte index and shift buffer; newest byte enters at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
      r_buf <= 24'd0;
    end else if (clr) begin
      r_idx <= 2'd0;
    end else if (byte_valid) begin
      r_idx <= r_idx + 2'd1;
      r_buf <= {byte_data, r_buf[23:8]};
    end
  end

  // After three bytes the buffer holds {b2,b1,b0}; the fourth completes it.
  always_comb begin
    word_valid = byte_valid && !clr && (r_idx == 2'd3);
    word_data  = {byte_data, r_buf};
  end

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : UART boot loader. Parses a length-prefixed byte stream,
//               writes packed words to instruction memory from address 0 and
//               holds the core in reset until the load finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR           = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit BOOT_RUN       = 1'b1
) (
  input wire logic         clk,
  input wire logic         rst,
  imem_load_ctrl_if.slave  bus
);

  localparam int              c_HDR_BITS   = LDR_HDR_BYTES * 8;
  localparam logic [16:0]     c_WORDS_MAX  = 17'(1 << (ADDR - 2));
  localparam int              c_IDLE_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam type_ldr_state_e c_RST_STATE  = BOOT_RUN ? ST_RUN : ST_IDLE;

  type_ldr_state_e       r_state;
  type_ldr_state_e       w_next;
  logic [c_HDR_BITS-1:0] r_n;
  logic [15:0]           r_words;
  logic [c_IDLE_W-1:0]   r_idle;
  type_ldr2imem_s        r_wr;
  logic                  r_core_rst;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_in_load;
  logic                  w_accept_req;
  logic                  w_byte;
  logic                  w_timeout;
  logic [15:0]           w_hdr_n;
  logic                  w_word_valid;
  logic [31:0]           w_word_data;

  // Event decode: a request beats a byte, a byte beats the timeout.
  always_comb begin
    w_in_load    = ldr_is_busy(r_state);
    w_accept_req = bus.load_req && (r_state != ST_DONE);
    w_byte       = w_in_load && bus.rx_valid && !bus.load_req;
    w_timeout    = w_in_load && !bus.rx_valid && !bus.load_req && (r_idle == c_IDLE_LAST);
    w_hdr_n      = {bus.rx_data, r_n[7:0]};
  end

  uart_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_accept_req),
    .byte_valid (w_byte && (r_state == ST_DATA)),
    .byte_data  (bus.rx_data),
    .word_valid (w_word_valid),
    .word_data  (w_word_data)
  );

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERR: if (w_accept_req) w_next = ST_HDR0;
      ST_HDR0: begin
        if (w_accept_req)   w_next = ST_HDR0;
        else if (w_byte)    w_next = ST_HDR1;
        else if (w_timeout) w_next = ST_ERR;
      end
      ST_HDR1: begin
        if (w_accept_req) begin
          w_next = ST_HDR0;
        end else if (w_byte) begin
          if (w_hdr_n == 16'd0)                    w_next = ST_DONE;
          else if ({1'b0, w_hdr_n} > c_WORDS_MAX)  w_next = ST_ERR;
          else                                     w_next = ST_DATA;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_DATA: begin
        if (w_accept_req)                                   w_next = ST_HDR0;
        else if (w_word_valid && (r_words + 16'd1 == r_n))  w_next = ST_DONE;
        else if (w_timeout)                                 w_next = ST_ERR;
      end
      ST_DONE: w_next = ST_RUN;
      default: w_next = c_RST_STATE;
    endcase
  end

  // State, counters and registered outputs (decoded from the next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_RST_STATE;
      r_n        <= '0;
      r_words    <= 16'd0;
      r_idle     <= '0;
      r_wr       <= '0;
      r_core_rst <= !BOOT_RUN;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_core_rst <= (w_next != ST_RUN);
      r_busy     <= ldr_is_busy(w_next);
      r_err      <= (w_next == ST_ERR);
      r_wr.we    <= 1'b0;
      if (w_accept_req) begin
        r_words <= 16'd0;
        r_idle  <= '0;
      end else if (w_in_load) begin
        r_idle <= bus.rx_valid ? '0 : r_idle + 1'b1;
        if (w_byte && (r_state == ST_HDR0)) r_n[7:0]  <= bus.rx_data;
        if (w_byte && (r_state == ST_HDR1)) r_n[15:8] <= bus.rx_data;
        if (w_word_valid) begin
          r_wr.we    <= 1'b1;
          r_wr.waddr <= r_words;
          r_wr.wdata <= w_word_data;
          r_words    <= r_words + 16'd1;
        end
      end
    end
  end

  assign bus.imem_we      = r_wr.we;
  assign bus.imem_waddr   = (ADDR - 2)'(r_wr.waddr);
  assign bus.imem_wdata   = BUS_WIDTH'(r_wr.wdata);
  assign bus.core_rst     = r_core_rst;
  assign bus.load_busy    = r_busy;
  assign bus.load_err     = r_err;
  assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_load_ctrl
// Description : Self-checking bench for the UART boot loader. Expected
//               memory contents come from a word list written by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] exp_words [0:299];

  imem_load_ctrl_if #(.BUS_WIDTH(32), .ADDR(10)) bus ();

  imem_load_ctrl #(
    .BUS_WIDTH      (32),
    .ADDR           (10),
    .TIMEOUT_CYCLES (16),
    .BOOT_RUN       (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write seen by the instruction memory.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) wq.push_back('{bus.imem_waddr, bus.imem_wdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    repeat ($urandom_range(0, maxgap)) tick();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  // Full load of exp_words[0..n-1]; checks each write and the release timing.
  task automatic do_load(input int n, input int maxgap, input bit skip_req);
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(n);
    wq.delete();
    if (!skip_req) begin
      pulse_req();
      chk("req_busy", 64'(bus.load_busy), 64'(1));
      chk("req_core_rst", 64'(bus.core_rst), 64'(1));
      chk("req_err_clr", 64'(bus.load_err), 64'(0));
      chk("req_words_clr", 64'(bus.words_loaded), 64'(0));
    end
    send(nn[7:0], maxgap);
    chk("hdr0_no_we", 64'(bus.imem_we), 64'(0));
    send(nn[15:8], maxgap);
    if (n == 0) begin
      chk("empty_busy", 64'(bus.load_busy), 64'(0));
      chk("empty_core_rst_done", 64'(bus.core_rst), 64'(1));
      tick();
      chk("empty_core_rst_run", 64'(bus.core_rst), 64'(0));
      chk("empty_no_write", 64'(wq.size()), 64'(0));
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = exp_words[i];
      for (int b = 0; b < 4; b++) begin
        send(w[8*b +: 8], maxgap);
        if (b == 3) begin
          chk("word_we", 64'(bus.imem_we), 64'(1));
          chk("word_addr", 64'(bus.imem_waddr), 64'(i));
          chk("word_data", 64'(bus.imem_wdata), 64'(w));
        end else begin
          chk("byte_no_we", 64'(bus.imem_we), 64'(0));
        end
      end
    end
    chk("last_busy", 64'(bus.load_busy), 64'(0));
    chk("last_core_rst_done", 64'(bus.core_rst), 64'(1));
    chk("last_words", 64'(bus.words_loaded), 64'(n));
    tick();
    chk("release_core_rst", 64'(bus.core_rst), 64'(0));
    chk("release_we_low", 64'(bus.imem_we), 64'(0));
    chk("write_count", 64'(wq.size()), 64'(n));
    for (int i = 0; i < wq.size() && i < n; i++) begin
      chk("image_addr", 64'(wq[i].a), 64'(i));
      chk("image_data", 64'(wq[i].d), 64'(exp_words[i]));
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.load_req = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset values with the preloaded image running.
    chk("rst_core_rst", 64'(bus.core_rst), 64'(0));
    chk("rst_we", 64'(bus.imem_we), 64'(0));
    chk("rst_waddr", 64'(bus.imem_waddr), 64'(0));
    chk("rst_wdata", 64'(bus.imem_wdata), 64'(0));
    chk("rst_busy", 64'(bus.load_busy), 64'(0));
    chk("rst_err", 64'(bus.load_err), 64'(0));
    chk("rst_words", 64'(bus.words_loaded), 64'(0));

    // Bytes without a request are ignored.
    wq.delete();
    for (int i = 0; i < 6; i++) send(8'($urandom), 1);
    chk("run_ignore_writes", 64'(wq.size()), 64'(0));
    chk("run_ignore_core_rst", 64'(bus.core_rst), 64'(0));
    chk("run_ignore_busy", 64'(bus.load_busy), 64'(0));

    // Directed two-word image, back to back.
    exp_words[0] = 32'h0000_0013;
    exp_words[1] = 32'h0010_0093;
    do_load(2, 0, 1'b0);

    // Empty image.
    do_load(0, 2, 1'b0);

    // Oversize header: 257 words with a 256-word memory.
    wq.delete();
    pulse_req();
    send(8'h01, 1);
    send(8'h01, 1);
    chk("big_err", 64'(bus.load_err), 64'(1));
    chk("big_busy", 64'(bus.load_busy), 64'(0));
    repeat (3) tick();
    chk("big_err_hold", 64'(bus.load_err), 64'(1));
    chk("big_core_rst_hold", 64'(bus.core_rst), 64'(1));
    chk("big_no_write", 64'(wq.size()), 64'(0));
    pulse_req();
    chk("big_err_cleared", 64'(bus.load_err), 64'(0));
    chk("big_restart_busy", 64'(bus.load_busy), 64'(1));
    for (int i = 0; i < 3; i++) exp_words[i] = $urandom;
    do_load(3, 2, 1'b1);

    // Random images with random inter-byte gaps.
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) exp_words[i] = $urandom;
      do_load(n, 3, 1'b0);
    end

    // Largest legal image, bytes on every cycle.
    for (int i = 0; i < 256; i++) exp_words[i] = $urandom;
    do_load(256, 0, 1'b0);

    // Timeout after two payload bytes.
    wq.delete();
    pulse_req();
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    repeat (15) tick();
    chk("to_not_yet", 64'(bus.load_err), 64'(0));
    chk("to_busy_before", 64'(bus.load_busy), 64'(1));
    tick();
    chk("to_err", 64'(bus.load_err), 64'(1));
    chk("to_busy_after", 64'(bus.load_busy), 64'(0));
    chk("to_core_rst", 64'(bus.core_rst), 64'(1));
    chk("to_words", 64'(bus.words_loaded), 64'(0));
    chk("to_no_write", 64'(wq.size()), 64'(0));

    // Request coincident with the third payload byte drops the byte.
    pulse_req();
    send(8'h01, 1);
    send(8'h00, 1);
    send(8'($urandom), 1);
    send(8'($urandom), 1);
    bus.load_req = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'($urandom);
    tick();
    bus.load_req = 1'b0;
    bus.rx_valid = 1'b0;
    chk("coinc_busy", 64'(bus.load_busy), 64'(1));
    chk("coinc_words", 64'(bus.words_loaded), 64'(0));
    exp_words[0] = $urandom;
    do_load(1, 1, 1'b1);

    // Asynchronous reset in the middle of the payload.
    for (int i = 0; i < 4; i++) exp_words[i] = $urandom;
    wq.delete();
    pulse_req();
    send(8'h04, 0);
    send(8'h00, 0);
    for (int b = 0; b < 6; b++) send(8'($urandom), 0);
    chk("mid_words", 64'(bus.words_loaded), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst_core_rst", 64'(bus.core_rst), 64'(0));
    chk("arst_busy", 64'(bus.load_busy), 64'(0));
    chk("arst_words", 64'(bus.words_loaded), 64'(0));
    chk("arst_we", 64'(bus.imem_we), 64'(0));
    chk("arst_wdata", 64'(bus.imem_wdata), 64'(0));
    bus.rx_valid = 1'b1;
    repeat (3) begin
      bus.rx_data = 8'($urandom);
      tick();
    end
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("arst_writes", 64'(wq.size()), 64'(1));
    chk("arst_after_core_rst", 64'(bus.core_rst), 64'(0));
    chk("arst_after_busy", 64'(bus.load_busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
